cv32e40p_alu_ft_reconfig: RTL



---
 rtl/cv32e40p_pkg.sv | 30 +++
 rtl/cv32e40p_alu_ft_reconfig.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared definitions for the fault-tolerant ALU cluster: replica count,
// reconfiguration FSM states and the spare-to-selection mapping.
package cv32e40p_pkg;

    localparam int ALU_FT_N_REPLICAS = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAKE,
        SWAP
    } alu_ft_reconfig_state_e;

    typedef struct packed {
        logic [ALU_FT_N_REPLICAS-2:0] sel;
        logic [ALU_FT_N_REPLICAS-1:0] clock_en;
    } alu_ft_sel_t;

    // The spare replica is excluded from voting and has its input pipe gated.
    function automatic alu_ft_sel_t alu_ft_spare_to_sel(input logic [1:0] spare);
        alu_ft_sel_t res;
        case (spare)
            2'd0:    begin res.sel = 3'b110; res.clock_en = 4'b1110; end
            2'd1:    begin res.sel = 3'b101; res.clock_en = 4'b1101; end
            2'd2:    begin res.sel = 3'b011; res.clock_en = 4'b1011; end
            default: begin res.sel = 3'b111; res.clock_en = 4'b0111; end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cv32e40p_alu_ft_reconfig.sv
// Reconfiguration controller: swaps the spare ALU replica in for a faulty
// voting replica at an instruction boundary after a wake-up period.
module cv32e40p_alu_ft_reconfig
    import cv32e40p_pkg::*;
#(
    parameter int WAKE_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ALU_FT_N_REPLICAS-1:0] perf_counter_permanent_faulty_alu_i,
    input  logic                         ex_ready_i,
    output logic [ALU_FT_N_REPLICAS-2:0] sel_mux_ex_o,
    output logic [ALU_FT_N_REPLICAS-1:0] clock_en_o,
    output logic [1:0]                   spare_id_o,
    output logic [ALU_FT_N_REPLICAS-1:0] faulty_alu_o,
    output logic                         reconfig_o,
    output logic                         degraded_o,
    output logic                         fatal_o
);

    localparam int CNT_W = (WAKE_CYCLES < 2) ? 1 : $clog2(WAKE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAKE_CYCLES - 1);

    alu_ft_reconfig_state_e       state_reg;
    logic [1:0]                   spare_reg;
    logic [1:0]                   target_reg;
    logic [CNT_W-1:0]             cnt_reg;
    logic [ALU_FT_N_REPLICAS-1:0] faulty_reg;
    logic [ALU_FT_N_REPLICAS-2:0] sel_reg;
    logic [ALU_FT_N_REPLICAS-1:0] clock_en_reg;
    logic                         reconfig_reg;
    logic                         degraded_reg;
    logic                         fatal_reg;

    logic [ALU_FT_N_REPLICAS-1:0] faulty_next;
    logic [ALU_FT_N_REPLICAS-1:0] active;
    logic [ALU_FT_N_REPLICAS-1:0] bad_act;
    logic [ALU_FT_N_REPLICAS-1:0] bad_act_next;
    logic [1:0]                   target_next;
    logic [2:0]                   bad_count;
    logic                         spare_failing;
    alu_ft_sel_t                  map_spare;
    alu_ft_sel_t                  map_target;

    assign faulty_next = faulty_reg | perf_counter_permanent_faulty_alu_i;

    genvar gi;
    generate
        for (gi = 0; gi < ALU_FT_N_REPLICAS; gi++) begin : g_active
            assign active[gi] = (spare_reg != 2'(gi));
        end
    endgenerate

    // Flags look at the registered mask; transitions include this cycle's triggers.
    assign bad_act       = faulty_reg & active;
    assign bad_act_next  = faulty_next & active;
    assign spare_failing = faulty_next[spare_reg];
    assign map_spare     = alu_ft_spare_to_sel(spare_reg);
    assign map_target    = alu_ft_spare_to_sel(target_reg);

    always_comb begin
        target_next = 2'd0;
        for (int i = ALU_FT_N_REPLICAS - 1; i >= 0; i--) begin
            if (bad_act_next[i]) target_next = 2'(i);
        end
    end

    always_comb begin
        bad_count = 3'd0;
        for (int i = 0; i < ALU_FT_N_REPLICAS; i++) begin
            bad_count = bad_count + 3'(bad_act[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            spare_reg    <= 2'd3;
            target_reg   <= 2'd0;
            cnt_reg      <= '0;
            faulty_reg   <= '0;
            sel_reg      <= 3'b111;
            clock_en_reg <= 4'b0111;
            reconfig_reg <= 1'b0;
            degraded_reg <= 1'b0;
            fatal_reg    <= 1'b0;
        end else begin
            faulty_reg   <= faulty_next;
            reconfig_reg <= 1'b0;
            degraded_reg <= (bad_act != '0) && faulty_reg[spare_reg];
            fatal_reg    <= (bad_count >= 3'd2);
            case (state_reg)
                IDLE: begin
                    if ((bad_act_next != '0) && !spare_failing) begin
                        target_reg   <= target_next;
                        cnt_reg      <= CNT_LOAD;
                        clock_en_reg <= 4'b1111;
                        state_reg    <= WAKE;
                    end
                end
                WAKE: begin
                    if (spare_failing) begin
                        clock_en_reg <= map_spare.clock_en;
                        state_reg    <= IDLE;
                    end else if (cnt_reg == '0) begin
                        state_reg <= SWAP;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                SWAP: begin
                    if (spare_failing) begin
                        clock_en_reg <= map_spare.clock_en;
                        state_reg    <= IDLE;
                    end else if (ex_ready_i) begin
                        spare_reg    <= target_reg;
                        sel_reg      <= map_target.sel;
                        clock_en_reg <= map_target.clock_en;
                        reconfig_reg <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign sel_mux_ex_o = sel_reg;
    assign clock_en_o   = clock_en_reg;
    assign spare_id_o   = spare_reg;
    assign faulty_alu_o = faulty_reg;
    assign reconfig_o   = reconfig_reg;
    assign degraded_o   = degraded_reg;
    assign fatal_o      = fatal_reg;

endmodule
